// File: rtl/serial_add_sub_ctrl_pkg.sv
// Shared constants and state encoding for the bit-serial adder/subtractor.
package serial_add_sub_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_sub_ctrl_if.sv
// Operand/result handshake bundle between the lab top level and the controller.
interface serial_add_sub_ctrl_if #(
  parameter int WIDTH = serial_add_sub_ctrl_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  // Requester side: issues operands and start, watches status/result.
  modport master (
    output start, sub, a, b,
    input  busy, done, result, carry_out, overflow
  );

  // Controller side.
  modport slave (
    input  start, sub, a, b,
    output busy, done, result, carry_out, overflow
  );
endinterface

// File: rtl/serial_add_sub_ctrl_fa_cell.sv
// Single combinational 1-bit full adder shared across all bit positions.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_add_sub_ctrl.sv
// Bit-serial add/subtract controller: feeds one full-adder cell LSB first,
// one bit per clock, and reports result/carry/overflow with a done pulse.
module serial_add_sub_ctrl
  import serial_add_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_add_sub_ctrl_if.slave bus
);

  // Wide enough to hold WIDTH-1 even for the smallest legal WIDTH.
  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_s;
  logic fa_cout;

  // The only adder in the datapath; operands always come from bit 0 of the shifters.
  fa_cell u_fa (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Sequencing: capture on start, shift one bit per cycle in RUN, pulse in DONE.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
          a_sh_d   = bus.a;
          b_sh_d   = bus.b ^ {WIDTH{bus.sub}};
          carry_d  = bus.sub;
          cnt_d    = '0;
          result_d = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        result_d = {fa_s, result_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = fa_cout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // carry_q here is the carry into the MSB; fa_cout is the carry out of it.
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// Bench for serial_add_sub_ctrl: directed cases plus random regression at
// WIDTH=8 and WIDTH=16 against an arithmetic reference model.
module tb_serial_add_sub_ctrl;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  serial_add_sub_ctrl_if #(.WIDTH(8))  if8 ();
  serial_add_sub_ctrl_if #(.WIDTH(16)) if16 ();

  serial_add_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  serial_add_sub_ctrl #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_inputs(input int w, input logic st, input logic [31:0] av,
                            input logic [31:0] bv, input logic sv);
    if (w == 16) begin
      if16.start = st; if16.a = av[15:0]; if16.b = bv[15:0]; if16.sub = sv;
    end else begin
      if8.start = st; if8.a = av[7:0]; if8.b = bv[7:0]; if8.sub = sv;
    end
  endtask

  task automatic sample(input int w, output logic busy, output logic done,
                        output logic [31:0] res, output logic co, output logic ov);
    if (w == 16) begin
      busy = if16.busy; done = if16.done; res = 32'(if16.result);
      co = if16.carry_out; ov = if16.overflow;
    end else begin
      busy = if8.busy; done = if8.done; res = 32'(if8.result);
      co = if8.carry_out; ov = if8.overflow;
    end
  endtask

  // Reference: modular add/sub with unsigned carry and signed overflow from sign rules.
  task automatic model(input int w, input logic [31:0] av, input logic [31:0] bv, input logic sv,
                       output logic [31:0] r, output logic c, output logic v);
    logic [32:0] full;
    logic [31:0] mask;
    logic        sa, sb, sr;
    mask = (w == 16) ? 32'h0000_FFFF : 32'h0000_00FF;
    if (sv) full = {1'b0, av & mask} + {1'b0, ~bv & mask} + 33'd1;
    else    full = {1'b0, av & mask} + {1'b0, bv & mask};
    r  = full[31:0] & mask;
    c  = full[w];
    sa = av[w-1];
    sb = bv[w-1];
    sr = r[w-1];
    if (sv) v = (sa != sb) && (sr != sa);
    else    v = (sa == sb) && (sr != sa);
  endtask

  // One full transaction: start, scramble operands after capture, wait for done, check.
  task automatic do_op(input int w, input logic [31:0] av, input logic [31:0] bv, input logic sv,
                       input string tag);
    logic [31:0] exp_r, res;
    logic        exp_c, exp_v, busy, done, co, ov;
    int          cyc;
    bit          got;
    model(w, av, bv, sv, exp_r, exp_c, exp_v);
    @(negedge clk);
    set_inputs(w, 1'b1, av, bv, sv);
    @(posedge clk);
    @(negedge clk);
    set_inputs(w, 1'b0, $urandom, $urandom, 1'($urandom));
    sample(w, busy, done, res, co, ov);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_clr"}, res, 32'd0);
    cyc = 0;
    got = 0;
    while (!got && cyc < 4 * w) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      sample(w, busy, done, res, co, ov);
      if (done) got = 1;
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(w));
    check({tag, "_result"}, res, exp_r);
    check({tag, "_cout"}, 32'(co), 32'(exp_c));
    check({tag, "_ovf"}, 32'(ov), 32'(exp_v));
    @(posedge clk);
    @(negedge clk);
    sample(w, busy, done, res, co, ov);
    check({tag, "_done_width"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, res, exp_r);
    $display("op w=%0d a=%0h b=%0h sub=%0b -> result=%0h cout=%0b ovf=%0b lat=%0d",
             w, av, bv, sv, res, co, ov, cyc);
  endtask

  initial begin
    logic [31:0] res;
    logic        busy, done, co, ov;
    int          cyc, ndone;
    bit          got;

    rst_n = 1'b0;
    set_inputs(8, 1'b0, 0, 0, 1'b0);
    set_inputs(16, 1'b0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    sample(8, busy, done, res, co, ov);
    check("rst_busy8", 32'(busy), 32'd0);
    check("rst_done8", 32'(done), 32'd0);
    check("rst_res8", res, 32'd0);
    check("rst_flags8", {30'd0, co, ov}, 32'd0);
    sample(16, busy, done, res, co, ov);
    check("rst_busy16", 32'(busy), 32'd0);
    check("rst_res16", res, 32'd0);
    $display("reset checked");
    rst_n = 1'b1;

    // Directed cases.
    do_op(8, 32'h3C, 32'h42, 1'b0, "add_3c_42");
    do_op(8, 32'h7F, 32'h01, 1'b0, "add_7f_01");
    do_op(8, 32'hFF, 32'h01, 1'b0, "add_ff_01");
    do_op(8, 32'h05, 32'h07, 1'b1, "sub_05_07");
    do_op(8, 32'h80, 32'h01, 1'b1, "sub_80_01");

    // Start re-pulsed during RUN and during DONE must be ignored.
    @(negedge clk);
    set_inputs(8, 1'b1, 32'h10, 32'h20, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_inputs(8, 1'b0, 32'hFF, 32'hFF, 1'b0);
    cyc = 0;
    got = 0;
    while (!got && cyc < 40) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      sample(8, busy, done, res, co, ov);
      if (done) got = 1;
      else if (cyc == 3) set_inputs(8, 1'b1, 32'hFF, 32'hFF, 1'b0);
      else set_inputs(8, 1'b0, 32'hFF, 32'hFF, 1'b0);
    end
    check("ign_done_seen", 32'(got), 32'd1);
    check("ign_latency", 32'(cyc), 32'd8);
    check("ign_result", res, 32'h30);
    set_inputs(8, 1'b1, 32'hFF, 32'hFF, 1'b0);
    @(posedge clk);
    @(negedge clk);
    sample(8, busy, done, res, co, ov);
    check("ign_done_busy", 32'(busy), 32'd0);
    set_inputs(8, 1'b0, 32'hFF, 32'hFF, 1'b0);
    ndone = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      sample(8, busy, done, res, co, ov);
      if (done) ndone++;
    end
    check("ign_no_extra_done", 32'(ndone), 32'd0);
    check("ign_result_hold", res, 32'h30);
    $display("ignore-start case result=%0h", res);

    // Reset during RUN aborts the operation.
    @(negedge clk);
    set_inputs(8, 1'b1, 32'h55, 32'h22, 1'b0);
    @(posedge clk);
    @(negedge clk);
    set_inputs(8, 1'b0, 32'h55, 32'h22, 1'b0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sample(8, busy, done, res, co, ov);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", res, 32'd0);
    ndone = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      sample(8, busy, done, res, co, ov);
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    $display("reset-abort case checked");
    do_op(8, 32'h01, 32'h01, 1'b0, "after_abort");

    // Random regression at both widths.
    for (int i = 0; i < 1000; i++)
      do_op(8, $urandom, $urandom, 1'($urandom), "rnd8");
    for (int i = 0; i < 1000; i++)
      do_op(16, $urandom, $urandom, 1'($urandom), "rnd16");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
